// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - one-hot router FSM state encoding and width helpers
package router_pkg;

    localparam int NUM_STATES = 9;

    typedef enum logic [NUM_STATES-1:0] {
        DECODE_ADDRESS     = 9'b0_0000_0001,
        WAIT_TILL_EMPTY    = 9'b0_0000_0010,
        LOAD_FIRST_DATA    = 9'b0_0000_0100,
        LOAD_DATA          = 9'b0_0000_1000,
        FIFO_FULL_STATE    = 9'b0_0001_0000,
        LOAD_AFTER_FULL    = 9'b0_0010_0000,
        LOAD_PARITY        = 9'b0_0100_0000,
        CHECK_PARITY_ERROR = 9'b0_1000_0000,
        DROP_PACKET        = 9'b1_0000_0000
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a field able to index 'count' items, never narrower than one bit.
    function automatic int addr_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// rtl/router_wait_timer.sv - watchdog counter for the WAIT_TILL_EMPTY phase
module router_wait_timer
    import router_pkg::*;
#(
    parameter int LIMIT   = 1024,
    parameter int COUNT_W = addr_width(LIMIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [COUNT_W-1:0] count;

    // Saturates at the limit so a held enable cannot wrap back to zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == COUNT_W'(LIMIT - 1));

endmodule

// File: rtl/router_fsm_np.sv
// rtl/router_fsm_np.sv - 1xN router control FSM with drop path; ROUTER_WAIT_TIMEOUT_EN adds a wait watchdog
module router_fsm_np
    import router_pkg::*;
#(
    parameter int NUM_PORTS      = 3,
    parameter int ADDR_W         = addr_width(NUM_PORTS),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    output logic [ADDR_W-1:0]    port_sel,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 drop_state,
    output logic                 timeout_err
);

    localparam int SEL_RANGE = 1 << ADDR_W;

    if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
        $error("router_fsm_np: NUM_PORTS must be 2..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("router_fsm_np: TIMEOUT_CYCLES must be at least 2");
    end

    state_t state;
    logic   wait_expire;

    // Zero-padded so addresses past NUM_PORTS read as "not empty, no soft reset".
    logic [SEL_RANGE-1:0] empty_ext;
    logic [SEL_RANGE-1:0] soft_ext;

    always_comb begin
        empty_ext                = '0;
        soft_ext                 = '0;
        empty_ext[NUM_PORTS-1:0] = fifo_empty;
        soft_ext[NUM_PORTS-1:0]  = soft_reset;
    end

    wire addr_invalid = (int'(data_in) >= NUM_PORTS);
    wire sel_empty    = empty_ext[port_sel];
    wire sel_soft_rst = soft_ext[port_sel];

`ifdef ROUTER_WAIT_TIMEOUT_EN
    router_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != WAIT_TILL_EMPTY),
        .enable (state == WAIT_TILL_EMPTY),
        .expire (wait_expire)
    );
`else
    assign wait_expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= DECODE_ADDRESS;
            port_sel    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state != DECODE_ADDRESS && sel_soft_rst) begin
                state <= DECODE_ADDRESS;
            end else begin
                case (state)
                    DECODE_ADDRESS: begin
                        if (pkt_valid) begin
                            port_sel <= data_in;
                            if (addr_invalid) begin
                                state <= DROP_PACKET;
                            end else if (empty_ext[data_in]) begin
                                state <= LOAD_FIRST_DATA;
                            end else begin
                                state <= WAIT_TILL_EMPTY;
                            end
                        end
                    end
                    WAIT_TILL_EMPTY: begin
                        if (sel_empty) begin
                            state <= LOAD_FIRST_DATA;
                        end else if (wait_expire) begin
                            state       <= DROP_PACKET;
                            timeout_err <= 1'b1;
                        end
                    end
                    LOAD_FIRST_DATA: state <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (fifo_full) begin
                            state <= FIFO_FULL_STATE;
                        end else if (!pkt_valid) begin
                            state <= LOAD_PARITY;
                        end
                    end
                    FIFO_FULL_STATE: begin
                        if (!fifo_full) begin
                            state <= LOAD_AFTER_FULL;
                        end
                    end
                    LOAD_AFTER_FULL: begin
                        if (parity_done) begin
                            state <= DECODE_ADDRESS;
                        end else if (low_packet_valid) begin
                            state <= LOAD_PARITY;
                        end else begin
                            state <= LOAD_DATA;
                        end
                    end
                    LOAD_PARITY: state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    end
                    DROP_PACKET: begin
                        if (!pkt_valid) begin
                            state <= DECODE_ADDRESS;
                        end
                    end
                    default: state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign busy          = (state == WAIT_TILL_EMPTY) || (state == LOAD_FIRST_DATA) ||
                           (state == FIFO_FULL_STATE) || (state == LOAD_AFTER_FULL) ||
                           (state == LOAD_PARITY)     || (state == CHECK_PARITY_ERROR);
    assign drop_state    = (state == DROP_PACKET);

endmodule

// File: tb/tb_router_fsm_np.sv
// tb/tb_router_fsm_np.sv - scoreboard bench for router_fsm_np against a behavioural model
module tb_router_fsm_np;

    localparam int NP = 3;
    localparam int TO = 8;

    typedef enum int {M_DA, M_WTE, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE, M_DROP} ms_t;

    typedef struct {
        logic [8:0] dec;
        logic [1:0] psel;
        logic       terr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [1:0]  data_in = '0;
    logic        fifo_full = 1'b0;
    logic [2:0]  fifo_empty = '1;
    logic [2:0]  soft_reset = '0;
    logic        parity_done = 1'b0;
    logic        low_packet_valid = 1'b0;
    logic [1:0]  port_sel;
    logic        detect_add, lfd_state, ld_state, laf_state, full_state;
    logic        rst_int_reg, write_enb_reg, busy, drop_state, timeout_err;

    router_fsm_np #(
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .soft_reset       (soft_reset),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .port_sel         (port_sel),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .write_enb_reg    (write_enb_reg),
        .busy             (busy),
        .drop_state       (drop_state),
        .timeout_err      (timeout_err)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    ms_t        m_state = M_DA;
    logic [1:0] m_psel  = '0;
    int         m_cnt   = 0;
    logic       m_terr  = 1'b0;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, drop}
    function automatic logic [8:0] exp_dec(input ms_t s);
        case (s)
            M_DA:    return 9'b1_0000_0000;
            M_WTE:   return 9'b0_0000_0010;
            M_LFD:   return 9'b0_1000_0010;
            M_LD:    return 9'b0_0100_0100;
            M_FFS:   return 9'b0_0001_0010;
            M_LAF:   return 9'b0_0010_0110;
            M_LP:    return 9'b0_0000_0110;
            M_CPE:   return 9'b0_0000_1010;
            default: return 9'b0_0000_0001;
        endcase
    endfunction

    task automatic step(input logic pv, input logic [1:0] din, input logic full,
                        input logic [2:0] emp, input logic [2:0] sr, input logic pd,
                        input logic lpv, input logic rst);
        exp_t e;
        @(negedge clock);
        pkt_valid        = pv;
        data_in          = din;
        fifo_full        = full;
        fifo_empty       = emp;
        soft_reset       = sr;
        parity_done      = pd;
        low_packet_valid = lpv;
        reset            = rst;
        m_terr = 1'b0;
        if (rst) begin
            m_state = M_DA;
            m_psel  = '0;
            m_cnt   = 0;
        end else if (m_state != M_DA && int'(m_psel) < NP && sr[m_psel]) begin
            m_state = M_DA;
        end else begin
            case (m_state)
                M_DA: if (pv) begin
                    m_psel = din;
                    if (int'(din) >= NP) m_state = M_DROP;
                    else if (emp[din]) m_state = M_LFD;
                    else begin
                        m_state = M_WTE;
                        m_cnt   = 0;
                    end
                end
                M_WTE: begin
                    if (emp[m_psel]) m_state = M_LFD;
`ifdef ROUTER_WAIT_TIMEOUT_EN
                    else if (m_cnt == TO - 1) begin
                        m_state = M_DROP;
                        m_terr  = 1'b1;
                    end else m_cnt = m_cnt + 1;
`endif
                end
                M_LFD:  m_state = M_LD;
                M_LD:   if (full) m_state = M_FFS; else if (!pv) m_state = M_LP;
                M_FFS:  if (!full) m_state = M_LAF;
                M_LAF:  m_state = pd ? M_DA : (lpv ? M_LP : M_LD);
                M_LP:   m_state = M_CPE;
                M_CPE:  m_state = full ? M_FFS : M_DA;
                M_DROP: if (!pv) m_state = M_DA;
                default: m_state = M_DA;
            endcase
        end
        e.dec  = exp_dec(m_state);
        e.psel = m_psel;
        e.terr = m_terr;
        exp_q.push_back(e);
    endtask

    task automatic go(input logic pv, input logic [1:0] din, input logic full, input logic [2:0] emp);
        step(pv, din, full, emp, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(posedge clock);
            #1;
            cycle = cycle + 1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {detect_add, lfd_state, ld_state, laf_state, full_state,
                       rst_int_reg, write_enb_reg, busy, drop_state};
                checks = checks + 1;
                if (act !== e.dec || port_sel !== e.psel || timeout_err !== e.terr) begin
                    errors = errors + 1;
                    $display("FAIL outputs cycle=%0d actual dec=%b port_sel=%0d timeout_err=%b required dec=%b port_sel=%0d timeout_err=%b",
                             cycle, act, port_sel, timeout_err, e.dec, e.psel, e.terr);
                end
            end
        end
    end

    initial begin : stimulus
        step(0, 0, 0, 3'b111, 0, 0, 0, 1);
        step(0, 0, 0, 3'b111, 0, 0, 0, 1);
        go(0, 0, 0, 3'b111);

        // Normal packet to port 1: header, first data, payload, parity.
        go(1, 2'b01, 0, 3'b111);
        go(1, 0, 0, 3'b111);
        for (int i = 0; i < 3; i++) go(1, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);

        // Port 2 busy for five cycles before its FIFO drains.
        go(1, 2'b10, 0, 3'b011);
        for (int i = 0; i < 4; i++) go(1, 0, 0, 3'b011);
        go(1, 0, 0, 3'b111);
        go(1, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);

        // Invalid address: six bytes discarded.
        go(1, 2'b11, 0, 3'b111);
        for (int i = 0; i < 5; i++) go(1, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);

        // Full mid-payload, then low_packet_valid after recovery.
        go(1, 2'b00, 0, 3'b111);
        go(1, 0, 0, 3'b111);
        for (int i = 0; i < 3; i++) go(1, 0, 1, 3'b111);
        go(1, 0, 0, 3'b111);
        go(1, 0, 0, 3'b111);
        go(1, 0, 1, 3'b111);
        go(1, 0, 0, 3'b111);
        step(0, 0, 0, 3'b111, 0, 0, 1, 0);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);

        // Soft reset on another port is ignored; on the selected port aborts.
        go(1, 2'b00, 0, 3'b111);
        go(1, 0, 0, 3'b111);
        go(1, 0, 0, 3'b111);
        step(1, 0, 0, 3'b111, 3'b010, 0, 0, 0);
        step(1, 0, 0, 3'b111, 3'b001, 0, 0, 0);
        go(0, 0, 0, 3'b111);
        go(1, 2'b01, 0, 3'b111);
        go(1, 0, 0, 3'b111);
        go(0, 0, 0, 3'b111);
        step(0, 0, 0, 3'b111, 0, 0, 0, 1);
        go(0, 0, 0, 3'b111);

`ifdef ROUTER_WAIT_TIMEOUT_EN
        // Port 2 never drains: watchdog drops the packet.
        go(1, 2'b10, 0, 3'b011);
        for (int i = 0; i < 10; i++) go(0, 0, 0, 3'b011);
        go(0, 0, 0, 3'b111);
`endif

        for (int i = 0; i < 2500; i++) begin
            logic       r_pv, r_full, r_pd, r_lpv, r_rst;
            logic [1:0] r_din;
            logic [2:0] r_emp, r_sr;
            r_pv  = ($urandom_range(0, 4) != 0);
            r_din = 2'($urandom_range(0, 3));
            r_full = ($urandom_range(0, 4) == 0);
            r_emp = 3'($urandom);
            r_sr  = ($urandom_range(0, 31) == 0) ? 3'($urandom) : 3'b000;
            r_pd  = ($urandom_range(0, 3) == 0);
            r_lpv = ($urandom_range(0, 3) == 0);
            r_rst = ($urandom_range(0, 99) == 0);
            step(r_pv, r_din, r_full, r_emp, r_sr, r_pd, r_lpv, r_rst);
        end

        repeat (4) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
